prbs_gen: RTL and testbench
===========================

Name: prbs_gen

Overview:
- Transmit-side 8-bit PRBS source feeding the LVDS TX serializer of the loopback link.
- Its sequence is consumed by the receive-side PRBS checker after deserialization.
- Emits a fixed training word for LVDS word alignment, then a seeded PRBS word stream.
- Supports single-word error injection and provides word/injection counters for link bring-up.

Parameters:
- TRAIN_WORD, 8'hF0, word driven in IDLE and TRAIN.
- TRAIN_CYCLES, 64, number of TRAIN words sent after enable rises (>=1).
- SEED_HOLD, 4, number of cycles the seed word is held with tx_test high before the sequence advances (>=1).
- CNT_W, 32, width of word_cnt.

Ports:
- clk  in  1  word clock, same as the serializer parallel clock.
- rstn  in  1  asynchronous, active-low reset.
- testen  in  1  test enable, asynchronous to clk; level.
- err_inj  in  1  error-injection request, asynchronous; rising edge = one request.
- tx_data  out  8  parallel word to the serializer, registered.
- tx_test  out  1  test-active flag forwarded to the far end; registered, aligned with tx_data.
- running  out  1  high in HOLD and RUN.
- word_cnt  out  CNT_W  PRBS words emitted in the current run (HOLD + RUN); wraps at 2^CNT_W.
- inj_cnt  out  16  errors injected since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release) drives these values:
  - state = IDLE, tx_data = TRAIN_WORD, tx_test = 0, running = 0.
  - word_cnt = 0, inj_cnt = 0, LFSR = 8'h08, all sync flops = 0.
- testen and err_inj each pass through a 2-flop synchronizer (en_s, inj_s).
  - An inj_s rising-edge detector produces a one-cycle inj_pulse.
- LFSR next state (p = current value):
  - n7=p1^p3, n6=p7^p1^p2, n5=p6^p7, n4=p5^p6, n3=p4^p5, n2=p3^p4, n1=p2^p3, n0=p1^p2.
  - Sequence from the seed: 08, 86, E2, 89, ...
- FSM:
  - IDLE: tx_data = TRAIN_WORD, tx_test = 0. en_s=1 -> TRAIN with train counter cleared.
  - TRAIN: tx_data = TRAIN_WORD for exactly TRAIN_CYCLES cycles, then -> HOLD.
  - HOLD: tx_data = 8'h08, tx_test = 1, LFSR frozen, for SEED_HOLD cycles, then -> RUN.
  - RUN: each cycle tx_data = LFSR value and the LFSR advances one step. The first RUN word is 8'h86.
- en_s=0 in any non-IDLE state:
  - Next cycle -> IDLE, tx_test = 0, LFSR reloaded to 8'h08, word_cnt cleared.
  - Takes priority over all other transitions.
- Output latency: tx_data and tx_test are registered, one cycle after the state that produces them.
- Error injection:
  - An inj_pulse in RUN or HOLD inverts tx_data[0] of the next emitted word only.
  - The LFSR is unaffected. inj_cnt increments.
  - An inj_pulse in IDLE or TRAIN is dropped and inj_cnt does not change.
  - Requests arriving while an inversion is pending merge into one.
- word_cnt increments once per HOLD/RUN word, including injected words.
- Reset mid-run behaves exactly like power-up reset.

Decomposition:
- Shared package prbs_pkg holds:
  - PRBS_SEED = 8'h08
  - a function prbs8_next(p) implementing the equations above
  - the FSM state enum {IDLE, TRAIN, HOLD, RUN}
- The RX checker uses the same function, so TX and RX cannot diverge.
- One sub-module, prbs8_lfsr, provides:
  - ports: clk, rstn, load_seed, advance, q[7:0]
  - load_seed has priority over advance.

Test Plan:
- Reset, then testen=1 held, TRAIN_CYCLES=4, SEED_HOLD=2 -> tx_data = F0 x4, 08 x2 (tx_test=1), then 86, E2, 89; word_cnt=5 after 89.
- Run 300 words -> tx_data matches a prbs8_next reference model for every word; the sequence repeats with its model-computed period.
- err_inj pulse mid-RUN where the expected word is 0xE2 -> tx_data=0xE3 for one word, next word 0x89, inj_cnt=1.
- err_inj during TRAIN -> no corruption, inj_cnt stays 0.
- testen dropped during RUN, then raised -> IDLE outputs F0 with tx_test=0, full TRAIN/HOLD replays, and the first RUN word is again 0x86.
- rstn asserted mid-RUN for one cycle -> outputs go to reset values immediately; after release with testen=1 the sequence restarts from TRAIN.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit PRBS link: seed, LFSR step function and FSM states.
// The RX checker imports this package so both ends step the sequence identically.
package prbs_pkg;

    localparam logic [7:0] PRBS_SEED = 8'h08;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } prbs_state_e;

    function automatic logic [7:0] prbs8_next(input logic [7:0] p);
        logic [7:0] n;
        n[7] = p[1] ^ p[3];
        n[6] = p[7] ^ p[1] ^ p[2];
        n[5] = p[6] ^ p[7];
        n[4] = p[5] ^ p[6];
        n[3] = p[4] ^ p[5];
        n[2] = p[3] ^ p[4];
        n[1] = p[2] ^ p[3];
        n[0] = p[1] ^ p[2];
        return n;
    endfunction

endpackage

// File: rtl/prbs8_lfsr.sv
// 8-bit PRBS state register; seed reload takes priority over stepping.
module prbs8_lfsr
    import prbs_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       load_seed,
    input  logic       advance,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= PRBS_SEED;
        end else if (load_seed) begin
            q <= PRBS_SEED;
        end else if (advance) begin
            q <= prbs8_next(q);
        end
    end

endmodule

// File: rtl/prbs_gen.sv
// TX PRBS source: training word, seed hold, then PRBS words, with single-word
// error injection and word/injection counters for link bring-up.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter logic [7:0] TRAIN_WORD   = 8'hF0,
    parameter int         TRAIN_CYCLES = 64,
    parameter int         SEED_HOLD    = 4,
    parameter int         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             testen,
    input  logic             err_inj,
    output logic [7:0]       tx_data,
    output logic             tx_test,
    output logic             running,
    output logic [CNT_W-1:0] word_cnt,
    output logic [15:0]      inj_cnt
);

    localparam int PH_MAX = (TRAIN_CYCLES > SEED_HOLD) ? TRAIN_CYCLES : SEED_HOLD;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam logic [PH_W-1:0] TRAIN_LAST = PH_W'(TRAIN_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(SEED_HOLD - 1);

    logic rst_meta, rst_n;
    logic en_meta, en_s;
    logic inj_meta, inj_s, inj_d, inj_pulse;
    logic inj_pend;

    prbs_state_e     state, state_nx;
    logic [PH_W-1:0] ph_cnt, ph_cnt_nx;
    logic            load_seed, advance, emit;
    logic [7:0]      tx_data_nx;
    logic            tx_test_nx;
    logic [7:0]      lfsr_q;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_meta  <= 1'b0;
            en_s     <= 1'b0;
            inj_meta <= 1'b0;
            inj_s    <= 1'b0;
            inj_d    <= 1'b0;
        end else begin
            en_meta  <= testen;
            en_s     <= en_meta;
            inj_meta <= err_inj;
            inj_s    <= inj_meta;
            inj_d    <= inj_s;
        end
    end

    assign inj_pulse = inj_s & ~inj_d;

    prbs8_lfsr u_lfsr (
        .clk       (clk),
        .rstn      (rst_n),
        .load_seed (load_seed),
        .advance   (advance),
        .q         (lfsr_q)
    );

    always_comb begin
        state_nx   = state;
        ph_cnt_nx  = ph_cnt;
        load_seed  = 1'b0;
        advance    = 1'b0;
        emit       = 1'b0;
        tx_data_nx = TRAIN_WORD;
        tx_test_nx = 1'b0;
        // Losing enable aborts any active state before anything else is considered.
        if (state != IDLE && !en_s) begin
            state_nx  = IDLE;
            load_seed = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    load_seed = 1'b1;
                    if (en_s) begin
                        state_nx  = TRAIN;
                        ph_cnt_nx = '0;
                    end
                end
                TRAIN: begin
                    if (ph_cnt == TRAIN_LAST) begin
                        state_nx  = HOLD;
                        ph_cnt_nx = '0;
                    end else begin
                        ph_cnt_nx = ph_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    tx_data_nx = PRBS_SEED;
                    tx_test_nx = 1'b1;
                    emit       = 1'b1;
                    if (ph_cnt == HOLD_LAST) begin
                        state_nx  = RUN;
                        ph_cnt_nx = '0;
                    end else begin
                        ph_cnt_nx = ph_cnt + 1'b1;
                    end
                end
                RUN: begin
                    tx_data_nx = prbs8_next(lfsr_q);
                    tx_test_nx = 1'b1;
                    emit       = 1'b1;
                    advance    = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // A pending inversion is consumed by the very next emitted word; pulses seen
    // while one is pending are absorbed into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph_cnt   <= '0;
            tx_data  <= TRAIN_WORD;
            tx_test  <= 1'b0;
            running  <= 1'b0;
            word_cnt <= '0;
            inj_cnt  <= '0;
            inj_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            ph_cnt   <= ph_cnt_nx;
            tx_data  <= tx_data_nx ^ {7'b0, inj_pend & emit};
            tx_test  <= tx_test_nx;
            running  <= emit;
            inj_pend <= emit & ~inj_pend & inj_pulse;
            if (emit) begin
                word_cnt <= word_cnt + 1'b1;
            end else begin
                word_cnt <= '0;
            end
            if (inj_pend && emit && inj_cnt != 16'hFFFF) begin
                inj_cnt <= inj_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen: training/hold/run framing, PRBS content and period,
// error injection, enable drop/replay and mid-run reset.
module tb_prbs_gen;

    localparam int TRN  = 4;
    localparam int HLD  = 2;
    localparam int NRUN = 300;

    logic        clk = 1'b0;
    logic        rstn;
    logic        testen;
    logic        err_inj;
    logic [7:0]  tx_data;
    logic        tx_test;
    logic        running;
    logic [31:0] word_cnt;
    logic [15:0] inj_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_w [NRUN];
    logic [7:0] cap   [NRUN];

    prbs_gen #(
        .TRAIN_WORD   (8'hF0),
        .TRAIN_CYCLES (TRN),
        .SEED_HOLD    (HLD),
        .CNT_W        (32)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .testen   (testen),
        .err_inj  (err_inj),
        .tx_data  (tx_data),
        .tx_test  (tx_test),
        .running  (running),
        .word_cnt (word_cnt),
        .inj_cnt  (inj_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_next(input logic [7:0] p);
        logic [7:0] n;
        n = {p[1] ^ p[3], p[7] ^ p[1] ^ p[2], p[6] ^ p[7], p[5] ^ p[6],
             p[4] ^ p[5], p[3] ^ p[4], p[2] ^ p[3], p[1] ^ p[2]};
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // lead = cycles after enabling before the first training word appears.
    task automatic run_seq(input int lead, input int nrun, input int inj_idx, input bit train_inj);
        int total;
        int inj_c;
        int i;
        logic [7:0] exp_w;
        total = lead + TRN + HLD + nrun;
        inj_c = (inj_idx >= 0) ? lead + TRN + HLD + 1 + inj_idx - 3 : -10;
        for (int c = 1; c <= total; c++) begin
            if (train_inj && c == lead) err_inj = 1'b1;
            if (c == inj_c) err_inj = 1'b1;
            if ((train_inj && c == lead + 3) || c == inj_c + 3) err_inj = 1'b0;
            step();
            if (c <= lead + TRN) begin
                check("train_data", tx_data, 8'hF0);
                check("train_test", tx_test, 1'b0);
                check("train_running", running, 1'b0);
            end else if (c <= lead + TRN + HLD) begin
                check("hold_data", tx_data, 8'h08);
                check("hold_test", tx_test, 1'b1);
                check("hold_running", running, 1'b1);
                check("hold_word_cnt", word_cnt, c - lead - TRN);
            end else begin
                i = c - lead - TRN - HLD - 1;
                exp_w = ref_w[i] ^ ((i == inj_idx) ? 8'h01 : 8'h00);
                cap[i] = tx_data;
                check("run_data", tx_data, exp_w);
                check("run_test", tx_test, 1'b1);
                check("run_word_cnt", word_cnt, HLD + i + 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        logic [7:0] s0, s;

        ref_w[0] = ref_next(8'h08);
        for (int k = 1; k < NRUN; k++) ref_w[k] = ref_next(ref_w[k-1]);

        rstn = 1'b0;
        testen = 1'b0;
        err_inj = 1'b0;
        repeat (3) step();
        check("rst_data", tx_data, 8'hF0);
        check("rst_test", tx_test, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_inj_cnt", inj_cnt, 0);

        rstn = 1'b1;
        repeat (6) step();
        check("idle_data", tx_data, 8'hF0);
        check("idle_test", tx_test, 1'b0);

        // First run, with a request arriving during training that must be ignored.
        testen = 1'b1;
        run_seq(3, 3, -1, 1'b1);
        check("first_w0", cap[0], 8'h86);
        check("first_w1", cap[1], 8'hE2);
        check("first_w2", cap[2], 8'h89);
        check("first_word_cnt", word_cnt, 5);
        check("train_inj_cnt", inj_cnt, 0);

        testen = 1'b0;
        repeat (3) step();
        check("drop_data", tx_data, 8'hF0);
        check("drop_test", tx_test, 1'b0);
        check("drop_running", running, 1'b0);
        check("drop_word_cnt", word_cnt, 0);

        // Replay after re-enable, injecting into the word expected to be E2.
        testen = 1'b1;
        run_seq(3, NRUN, 1, 1'b0);
        check("inj_w0", cap[0], 8'h86);
        check("inj_w1", cap[1], 8'hE3);
        check("inj_w2", cap[2], 8'h89);
        check("inj_cnt_one", inj_cnt, 1);

        s0 = ref_w[8];
        s = ref_next(s0);
        p = 1;
        while (s != s0 && p < 256) begin
            s = ref_next(s);
            p++;
        end
        check("period_found", s == s0, 1'b1);
        for (int j = 8; j + p < NRUN; j++) check("period_repeat", cap[j+p], ref_w[j]);

        // One-cycle reset in the middle of RUN.
        rstn = 1'b0;
        #1;
        check("midrst_data", tx_data, 8'hF0);
        check("midrst_test", tx_test, 1'b0);
        check("midrst_running", running, 1'b0);
        check("midrst_word_cnt", word_cnt, 0);
        check("midrst_inj_cnt", inj_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;
        run_seq(5, 3, -1, 1'b0);
        check("restart_w0", cap[0], 8'h86);
        check("restart_inj_cnt", inj_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
